// File: rtl/exerion_input_pkg.sv
// Shared definitions for the Exerion input conditioner.
//  - bit positions of joy_in and controls_n
//  - coin FSM and opposing-direction selector state types
//  - helpers: max3 for counter sizing and socd_next for direction arbitration
package exerion_input_pkg;

   // joy_in bit positions (active-high)
   localparam int unsigned J_RIGHT    = 0;
   localparam int unsigned J_LEFT     = 1;
   localparam int unsigned J_DOWN     = 2;
   localparam int unsigned J_UP       = 3;
   localparam int unsigned J_FIRE     = 4;
   localparam int unsigned J_FASTFIRE = 5;
   localparam int unsigned J_START1   = 6;
   localparam int unsigned J_START2   = 7;
   localparam int unsigned J_COIN     = 8;
   localparam int unsigned J_PAUSE    = 9;

   // controls_n bit positions (active-low)
   localparam int unsigned C_RIGHT  = 0;
   localparam int unsigned C_LEFT   = 1;
   localparam int unsigned C_DOWN   = 2;
   localparam int unsigned C_UP     = 3;
   localparam int unsigned C_SHOOT  = 4;
   localparam int unsigned C_SHOOT2 = 5;
   localparam int unsigned C_START1 = 6;
   localparam int unsigned C_START2 = 7;
   localparam int unsigned C_COIN   = 8;

   typedef enum logic [1:0] {COIN_IDLE, COIN_ON, COIN_OFF} coin_state_e;

   // Which member of an opposing pair is currently driven (A = first input).
   typedef enum logic [1:0] {SOCD_NONE, SOCD_A, SOCD_B} socd_sel_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Most recent press wins; simultaneous presses cancel until one is released.
   function automatic socd_sel_e socd_next(input socd_sel_e cur, input logic a, input logic b,
                                           input logic a_rise, input logic b_rise);
      socd_sel_e nxt;
      nxt = cur;
      if (a && b) begin
         if (a_rise && !b_rise)      nxt = SOCD_A;
         else if (b_rise && !a_rise) nxt = SOCD_B;
         else if (a_rise && b_rise)  nxt = SOCD_NONE;
      end else if (a) begin
         nxt = SOCD_A;
      end else if (b) begin
         nxt = SOCD_B;
      end else begin
         nxt = SOCD_NONE;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/exerion_input_cond_if.sv
// Joystick-to-core control bundle.
//  joy_in[9:0]     raw joystick bits, active-high
//  pause_cpu       core paused
//  controls_n[8:0] conditioned CONTROLS bus, active-low
//  coin_busy       coin sequencer still working
interface exerion_input_cond_if;
   logic [9:0] joy_in;
   logic       pause_cpu;
   logic [8:0] controls_n;
   logic       coin_busy;

   modport master (output joy_in, output pause_cpu, input controls_n, input coin_busy);
   modport slave  (input joy_in, input pause_cpu, output controls_n, output coin_busy);
endinterface

// File: rtl/exerion_ms_tick.sv
// Millisecond prescaler.
//  clk_sys  system clock
//  reset    asynchronous active-high reset
//  en       advance enable (count holds while low)
//  ms_tick  high for one cycle every CLK_HZ/1000 enabled cycles
module exerion_ms_tick #(
   parameter int unsigned CLK_HZ = 20_000_000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic en,
   output logic ms_tick
);
   localparam int unsigned DIV = (CLK_HZ / 1000 < 2) ? 2 : CLK_HZ / 1000;
   localparam int unsigned PW  = $clog2(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] ONE  = PW'(1);

   logic [PW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d   = cnt_q;
      ms_tick = 1'b0;
      if (en) begin
         if (cnt_q == LAST) begin
            cnt_d   = '0;
            ms_tick = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/exerion_input_cond.sv
// Conditions MiSTer joystick bits into the active-low CONTROLS bus of exerion_fpga.
//  clk_sys  system clock
//  reset    asynchronous active-high reset
//  io       slave side of exerion_input_cond_if (joy_in, pause_cpu -> controls_n, coin_busy)
// Coin pulse shaping with a saturating queue, Fast Fire autofire, opposing-direction
// resolution and output blanking while paused.
module exerion_input_cond
   import exerion_input_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 20_000_000,
   parameter int unsigned COIN_ON_MS  = 50,
   parameter int unsigned COIN_OFF_MS = 50,
   parameter int unsigned COIN_QUEUE  = 3,
   parameter int unsigned AUTOFIRE_MS = 33
) (
   input logic                  clk_sys,
   input logic                  reset,
   exerion_input_cond_if.slave  io
);
   localparam int unsigned CW = $clog2(max3(COIN_ON_MS, COIN_OFF_MS, AUTOFIRE_MS) + 1);
   localparam int unsigned QW = $clog2(COIN_QUEUE + 1);
   localparam logic [CW-1:0] ON_N   = CW'(COIN_ON_MS);
   localparam logic [CW-1:0] OFF_N  = CW'(COIN_OFF_MS);
   localparam logic [CW-1:0] AF_N   = CW'(AUTOFIRE_MS);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [QW-1:0] Q_MAX  = QW'(COIN_QUEUE);
   localparam logic [QW-1:0] Q_ONE  = QW'(1);

   logic [8:0]  joy, rise, prev_q;
   logic        pause, tick, q_inc, q_dec;
   logic        unused_pause_btn;
   coin_state_e state_q, state_d;
   socd_sel_e   lr_q, lr_d, ud_q, ud_d;
   logic [CW-1:0] cnt_q, cnt_d, af_cnt_q, af_cnt_d;
   logic [QW-1:0] q_q, q_d;
   logic        phase_q, phase_d;
   logic [8:0]  ctl_q, ctl_d;

   // The pause button is consumed by the pause block upstream.
   assign unused_pause_btn = io.joy_in[J_PAUSE];
   assign joy   = io.joy_in[8:0];
   assign pause = io.pause_cpu;
   assign rise  = joy & ~prev_q;

   exerion_ms_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk_sys (clk_sys),
      .reset   (reset),
      .en      (~pause),
      .ms_tick (tick)
   );

   // Coin queue: a full queue drops the edge; the IDLE->ON pop is held off while paused.
   always_comb begin
      q_inc = rise[J_COIN] && (q_q != Q_MAX);
      q_dec = (state_q == COIN_IDLE) && (q_q != '0) && !pause;
      q_d   = q_q;
      if (q_inc && !q_dec)      q_d = q_q + Q_ONE;
      else if (q_dec && !q_inc) q_d = q_q - Q_ONE;
   end

   // Coin FSM. A phase ends on the tick seen with the counter already at N,
   // so each phase lasts N..N+1 ms from entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         COIN_IDLE: if (q_dec) begin
            state_d = COIN_ON;
            cnt_d   = '0;
         end
         COIN_ON: if (tick) begin
            if (cnt_q == ON_N) begin
               state_d = COIN_OFF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end
         COIN_OFF: if (tick) begin
            if (cnt_q == OFF_N) begin
               state_d = COIN_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
         end
         default: begin
            state_d = COIN_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Autofire. The toggling tick counts as the first tick of the next half-period,
   // giving exactly AUTOFIRE_MS ticks per half-period after the first one.
   always_comb begin
      phase_d  = phase_q;
      af_cnt_d = af_cnt_q;
      if (rise[J_FASTFIRE]) begin
         phase_d  = 1'b1;
         af_cnt_d = '0;
      end else if (joy[J_FASTFIRE] && tick) begin
         if (af_cnt_q == AF_N) begin
            phase_d  = ~phase_q;
            af_cnt_d = C_ONE;
         end else begin
            af_cnt_d = af_cnt_q + C_ONE;
         end
      end
   end

   always_comb begin
      lr_d  = socd_next(lr_q, joy[J_RIGHT], joy[J_LEFT], rise[J_RIGHT], rise[J_LEFT]);
      ud_d  = socd_next(ud_q, joy[J_UP], joy[J_DOWN], rise[J_UP], rise[J_DOWN]);
      ctl_d = '1;
      if (!pause) begin
         ctl_d[C_RIGHT]  = ~(lr_d == SOCD_A);
         ctl_d[C_LEFT]   = ~(lr_d == SOCD_B);
         ctl_d[C_UP]     = ~(ud_d == SOCD_A);
         ctl_d[C_DOWN]   = ~(ud_d == SOCD_B);
         ctl_d[C_SHOOT]  = ~(joy[J_FIRE] | (joy[J_FASTFIRE] & phase_d));
         ctl_d[C_SHOOT2] = ~joy[J_FASTFIRE];
         ctl_d[C_START1] = ~joy[J_START1];
         ctl_d[C_START2] = ~joy[J_START2];
         ctl_d[C_COIN]   = ~(state_d == COIN_ON);
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         prev_q   <= '0;
         state_q  <= COIN_IDLE;
         cnt_q    <= '0;
         q_q      <= '0;
         phase_q  <= 1'b1;
         af_cnt_q <= '0;
         lr_q     <= SOCD_NONE;
         ud_q     <= SOCD_NONE;
         ctl_q    <= '1;
      end else begin
         prev_q   <= joy;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         q_q      <= q_d;
         phase_q  <= phase_d;
         af_cnt_q <= af_cnt_d;
         lr_q     <= lr_d;
         ud_q     <= ud_d;
         ctl_q    <= ctl_d;
      end
   end

   assign io.controls_n = ctl_q;
   assign io.coin_busy  = (state_q != COIN_IDLE) || (q_q != '0);
endmodule

// File: tb/tb_exerion_input_cond.sv
module tb_exerion_input_cond;
   logic clk_sys = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk_sys = ~clk_sys;

   exerion_input_cond_if io ();

   exerion_input_cond #(
      .CLK_HZ      (20_000),
      .COIN_ON_MS  (3),
      .COIN_OFF_MS (2),
      .COIN_QUEUE  (3),
      .AUTOFIRE_MS (2)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .io      (io)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // Counts high samples until the coin line goes low, then low samples until it rises.
   task automatic wait_pulse(output int gap, output int len);
      gap = 0;
      len = 0;
      while (io.controls_n[8] !== 1'b0 && gap < 400) begin step(); gap++; end
      while (io.controls_n[8] === 1'b0 && len < 400) begin step(); len++; end
   endtask

   task automatic coin_edge();
      io.joy_in[8] = 1'b1; step();
      io.joy_in[8] = 1'b0; step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, len, cnt, bad, toggles, last, low_pre;
      logic prev_shoot;
      logic [8:0] prev_m, j, e;
      int unsigned t_press [4];

      reset = 1'b1;
      io.joy_in = '0;
      io.pause_cpu = 1'b0;
      repeat (3) step();
      chk("reset_ctl_held", 32'(io.controls_n), 32'h1FF);
      reset = 1'b0;
      step();
      chk("reset_ctl", 32'(io.controls_n), 32'h1FF);
      chk("reset_busy", 32'(io.coin_busy), 32'h0);

      // 1: single-register latency
      io.joy_in[0] = 1'b1;
      #2;
      chk("lat_before_edge", 32'(io.controls_n[0]), 32'h1);
      step();
      chk("lat_right", 32'(io.controls_n), 32'h1FE);
      io.joy_in = 10'h0D0;
      step();
      chk("lat_fire_starts", 32'(io.controls_n), 32'h12F);
      io.joy_in = '0;
      step();

      // 2: opposing directions
      io.joy_in[1] = 1'b1;
      repeat (5) step();
      chk("socd_left_only", 32'(io.controls_n[1:0]), 32'h1);
      io.joy_in[0] = 1'b1; step();
      chk("socd_right_wins", 32'(io.controls_n[1:0]), 32'h2);
      io.joy_in[0] = 1'b0; step();
      chk("socd_left_back", 32'(io.controls_n[1:0]), 32'h1);
      io.joy_in = '0; step();
      io.joy_in[1:0] = 2'b11; step();
      chk("socd_lr_same", 32'(io.controls_n[1:0]), 32'h3);
      repeat (3) step();
      chk("socd_lr_same_hold", 32'(io.controls_n[1:0]), 32'h3);
      io.joy_in[0] = 1'b0; step();
      chk("socd_lr_release", 32'(io.controls_n[1:0]), 32'h1);
      io.joy_in = '0; step();
      io.joy_in[3:2] = 2'b11; step();
      chk("socd_ud_same", 32'(io.controls_n[3:2]), 32'h3);
      io.joy_in[3] = 1'b0; step();
      chk("socd_ud_release", 32'(io.controls_n[3:2]), 32'h2);
      io.joy_in = '0; step();

      // Randomized directions/fire/starts against a press-timestamp model
      prev_m = '0;
      for (int k = 0; k < 4; k++) t_press[k] = 0;
      for (int n = 0; n < 300; n++) begin
         j = prev_m ^ (9'($urandom()) & 9'($urandom()) & 9'h0DF);
         for (int b = 0; b < 4; b++)
            if (j[b] && !prev_m[b]) t_press[b] = 32'(n) + 1;
         e = 9'h1FF;
         e[0] = ~(j[0] && (!j[1] || t_press[0] > t_press[1]));
         e[1] = ~(j[1] && (!j[0] || t_press[1] > t_press[0]));
         e[3] = ~(j[3] && (!j[2] || t_press[3] > t_press[2]));
         e[2] = ~(j[2] && (!j[3] || t_press[2] > t_press[3]));
         e[4] = ~j[4];
         e[6] = ~j[6];
         e[7] = ~j[7];
         io.joy_in = {1'b0, j};
         prev_m = j;
         step();
         chk("rand_ctl", 32'(io.controls_n), 32'(e));
      end
      io.joy_in = '0;
      repeat (2) step();

      // 4: autofire
      io.joy_in[5] = 1'b1; step();
      chk("af_start_shoot", 32'(io.controls_n[4]), 32'h0);
      prev_shoot = io.controls_n[4];
      bad = 0; toggles = 0; last = 0; cnt = 0;
      for (int c = 1; c < 200; c++) begin
         step();
         if (io.controls_n[5] !== 1'b0) cnt++;
         if (io.controls_n[4] !== prev_shoot) begin
            if (c - last < 40 || c - last > 60) bad++;
            toggles++;
            last = c;
            prev_shoot = io.controls_n[4];
         end
      end
      chk("af_shoot2_low", 32'(cnt), 32'h0);
      chk("af_interval_bad", 32'(bad), 32'h0);
      chk("af_toggles", 32'(toggles), 32'h4);
      io.joy_in = '0;
      repeat (2) step();

      // 3: four coin edges captured while held -> three pulses
      io.pause_cpu = 1'b1;
      step();
      repeat (4) coin_edge();
      chk("q_busy_paused", 32'(io.coin_busy), 32'h1);
      chk("q_ctl_paused", 32'(io.controls_n), 32'h1FF);
      io.pause_cpu = 1'b0;
      for (int p = 0; p < 3; p++) begin
         wait_pulse(gap, len);
         chk("q_pulse_len_ok", 32'(len >= 60 && len <= 80), 32'h1);
         if (p > 0) chk("q_gap_ok", 32'(gap >= 40 && gap < 400), 32'h1);
      end
      cnt = 0;
      while (io.coin_busy === 1'b1 && cnt < 200) begin step(); cnt++; end
      chk("q_busy_fall_ok", 32'(cnt >= 40 && cnt <= 61), 32'h1);
      cnt = 0;
      for (int c = 0; c < 300; c++) begin
         step();
         if (io.controls_n[8] === 1'b0) cnt++;
      end
      chk("q_no_fourth", 32'(cnt), 32'h0);

      // 5: pause in the middle of a pulse
      coin_edge();
      cnt = 0;
      while (io.controls_n[8] !== 1'b0 && cnt < 100) begin step(); cnt++; end
      chk("p_pulse_started", 32'(io.controls_n[8]), 32'h0);
      low_pre = 1;
      for (int c = 0; c < 30; c++) begin
         step();
         if (io.controls_n[8] === 1'b0) low_pre++;
      end
      io.pause_cpu = 1'b1;
      bad = 0;
      for (int c = 0; c < 500; c++) begin
         io.joy_in[8] = (c == 100);
         step();
         if (io.controls_n !== 9'h1FF) bad++;
      end
      chk("p_blanked", 32'(bad), 32'h0);
      io.pause_cpu = 1'b0;
      cnt = 0;
      step();
      while (io.controls_n[8] === 1'b0 && cnt < 200) begin cnt++; step(); end
      chk("p_on_total_ok", 32'(low_pre + cnt >= 60 && low_pre + cnt <= 80), 32'h1);
      wait_pulse(gap, len);
      chk("p_queued_gap_ok", 32'(gap >= 40 && gap < 400), 32'h1);
      chk("p_queued_len_ok", 32'(len >= 60 && len <= 80), 32'h1);
      cnt = 0;
      while (io.coin_busy === 1'b1 && cnt < 200) begin step(); cnt++; end
      chk("p_busy_fall", 32'(io.coin_busy), 32'h0);

      // 6: reset in the middle of a pulse, with coins queued
      repeat (3) coin_edge();
      repeat (20) step();
      chk("r_pulse_active", 32'(io.controls_n[8]), 32'h0);
      #2;
      reset = 1'b1;
      #1;
      chk("r_async_coin", 32'(io.controls_n[8]), 32'h1);
      chk("r_async_busy", 32'(io.coin_busy), 32'h0);
      step();
      step();
      reset = 1'b0;
      cnt = 0;
      for (int c = 0; c < 400; c++) begin
         step();
         if (io.controls_n[8] === 1'b0 || io.coin_busy === 1'b1) cnt++;
      end
      chk("r_no_pulse", 32'(cnt), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
